consmax_bus_drain: RTL and testbench
====================================

Name: consmax_bus_drain

Overview:
- Downstream stage of consmax_bus. Captures the per-head ConSmax output words (GBUS_WIDTH lanes × 8 bit per head) and buffers them in one small FIFO per head.
- Drains all heads round-robin onto a single GBUS_DATA-wide valid/ready bus, tagging each word with its head index, for the PV-matmul write path.
- consmax_bus has no backpressure input, so this block absorbs bursts and flags overflow and lane-misalignment errors.

Parameters:
- GBUS_DATA, 32, bits per head word (GBUS_WIDTH × ODATA_BIT)
- GBUS_WIDTH, 4, lanes per head word
- ODATA_BIT, 8, bits per lane
- NUM_HEAD, 4, number of heads (≥2)
- FIFO_DEPTH, 4, words per head FIFO (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cns_odata  in  GBUS_DATA*NUM_HEAD  consmax_bus odata; head h at [h*GBUS_DATA +: GBUS_DATA]
- cns_odata_valid  in  GBUS_WIDTH*NUM_HEAD  per-lane valid; head h at [h*GBUS_WIDTH +: GBUS_WIDTH]
- out_data  out  GBUS_DATA  drained word
- out_head  out  $clog2(NUM_HEAD)  head index of out_data
- out_valid  out  1  out_data/out_head valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- fifo_full  out  NUM_HEAD  per-head FIFO full (registered count == FIFO_DEPTH)
- ovf_err  out  NUM_HEAD  sticky: word dropped, FIFO full
- lane_err  out  NUM_HEAD  sticky: partial lane valid seen
- err_clr  in  1  clears ovf_err and lane_err

Behaviour:
- Reset (rst=1 at a posedge): all FIFO pointers/counts 0; out_valid=0, out_data=0, out_head=0; fifo_full=0, ovf_err=0, lane_err=0; round-robin pointer = head 0. Reset mid-operation discards all buffered words; out_valid drops after that edge.
- Capture, per head h, each cycle:
  - Push when all GBUS_WIDTH lane valids of h are 1; data is written unmodified.
  - If 1 ≤ popcount(lane valids) < GBUS_WIDTH: no push; lane_err[h] set.
  - If all valids are 0: nothing happens.
- Full FIFO:
  - Push to a full FIFO is dropped and sets ovf_err[h], unless the same head is popped in the same cycle. In that case the push succeeds and the count is unchanged.
  - Simultaneous push and pop on a non-full FIFO: count unchanged, order preserved.
- Empty FIFO: never popped. A word pushed in a cycle is not poppable until the next cycle; there is no bypass.
- Output stage is a single register:
  - It loads when (!out_valid || out_ready) and at least one FIFO is non-empty.
  - Loading pops the granted FIFO in the same cycle.
  - If it does not load and out_ready=1, out_valid clears.
  - out_data and out_head are held stable while out_valid && !out_ready.
- Arbitration is round-robin over non-empty FIFOs:
  - Search starts at rr_ptr and wraps modulo NUM_HEAD.
  - After a grant to head g, rr_ptr = (g+1) mod NUM_HEAD.
  - rr_ptr does not move without a grant.
- Latency: a word captured at edge E appears on out_* after edge E+1, given the output stage is free and the head wins arbitration. Sustained throughput is 1 word/cycle.
- Error flags: err_clr=1 clears both flag vectors. If err_clr and a set condition occur in the same cycle, set wins.
- fifo_full reflects the post-edge count.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The count is $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package consmax_drain_pkg holds:
  - localparam HEAD_IDX_W = $clog2(NUM_HEAD);
  - a head-word typedef logic [GBUS_DATA-1:0];
  - function next_rr(ptr, req_vec), returning the round-robin grant index.
- Sub-module consmax_head_fifo (one instance per head): synchronous FIFO, FIFO_DEPTH × GBUS_DATA.
  - Inputs: push, pop.
  - Outputs: rdata (head-of-queue, combinational read), empty, full, count.
  - Internally implements push-on-full-with-pop.
- Top level contains: lane-valid decode, error flags, arbiter, output register.

Test Plan:
- Single word: after reset, head 2 gets lanes valid=4'hF, data 32'hA1B2C3D4 for 1 cycle, out_ready=1 → out_valid=1 with out_data=32'hA1B2C3D4, out_head=2 exactly 2 edges after capture; out_valid=0 next cycle.
- Round-robin: all 4 heads push one word in the same cycle (data 32'h0000_000h for head h), out_ready=1 → out_head sequence 0,1,2,3 on consecutive cycles; rr_ptr ends at 0.
- Backpressure/overflow:
  - Setup: out_ready=0, head 1 pushes 6 consecutive words 1..6.
  - Expected: out holds word 1; FIFO holds 2..5; fifo_full[1]=1; word 6 dropped; ovf_err=4'b0010.
  - Then out_ready=1 → words 1,2,3,4,5 drain in order.
- Full with simultaneous pop: head 0 FIFO full, out_valid=1, out_ready=1, head 0 pushes 32'hDEAD0001 in the same cycle → no ovf_err; 32'hDEAD0001 emerges last in order.
- Partial lanes: head 3 lane valids 4'b0110 → no output word; lane_err=4'b1000. Assert err_clr together with a new partial on head 3 → lane_err stays 4'b1000. err_clr alone → 0.
- Reset mid-stream: 3 words buffered and out_valid=1, assert rst 1 cycle → all outputs 0 after that edge; no stale words ever appear.

Source files
------------

// File: rtl/consmax_drain_pkg.sv
// Shared constants, head-word type and round-robin helper for the consmax_bus drain stage.
package consmax_drain_pkg;

  localparam int unsigned GBUS_WIDTH = 4;
  localparam int unsigned ODATA_BIT  = 8;
  localparam int unsigned GBUS_DATA  = GBUS_WIDTH * ODATA_BIT;
  localparam int unsigned NUM_HEAD   = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned HEAD_IDX_W = $clog2(NUM_HEAD);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

  typedef logic [GBUS_DATA-1:0] head_word_t;

  // First requesting head at or after ptr, wrapping; returns ptr when nothing requests.
  function automatic logic [HEAD_IDX_W-1:0] next_rr(input logic [HEAD_IDX_W-1:0] ptr,
                                                    input logic [NUM_HEAD-1:0]   req_vec);
    logic [HEAD_IDX_W-1:0] grant;
    logic                  found;
    int unsigned           idx;
    grant = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_HEAD; i++) begin
      idx = (32'(ptr) + i) % NUM_HEAD;
      if (!found && req_vec[idx]) begin
        grant = HEAD_IDX_W'(idx);
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/consmax_head_fifo.sv
// Per-head synchronous FIFO; a push into a full FIFO is accepted only when the same cycle pops.
module consmax_head_fifo
  import consmax_drain_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  head_word_t       wdata,
  output head_word_t       rdata,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  head_word_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/consmax_bus_drain.sv
// Buffers per-head consmax_bus words and drains them round-robin onto one valid/ready bus.
module consmax_bus_drain
  import consmax_drain_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [GBUS_DATA*NUM_HEAD-1:0]  cns_odata,
  input  logic [GBUS_WIDTH*NUM_HEAD-1:0] cns_odata_valid,
  output logic [GBUS_DATA-1:0]           out_data,
  output logic [HEAD_IDX_W-1:0]          out_head,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_HEAD-1:0]            fifo_full,
  output logic [NUM_HEAD-1:0]            ovf_err,
  output logic [NUM_HEAD-1:0]            lane_err,
  input  logic                           err_clr
);

  head_word_t            rdata [NUM_HEAD];
  logic [CNT_W-1:0]      count [NUM_HEAD];
  logic [NUM_HEAD-1:0]   push;
  logic [NUM_HEAD-1:0]   partial;
  logic [NUM_HEAD-1:0]   pop;
  logic [NUM_HEAD-1:0]   empty;
  logic [NUM_HEAD-1:0]   full;
  logic [HEAD_IDX_W-1:0] rr_ptr;
  logic [HEAD_IDX_W-1:0] grant;
  logic                  load;

  assign grant = next_rr(rr_ptr, ~empty);
  assign load  = (!out_valid || out_ready) && (|(~empty));

  for (genvar h = 0; h < NUM_HEAD; h++) begin : g_head
    logic [GBUS_WIDTH-1:0] lane_v;
    assign lane_v     = cns_odata_valid[h*GBUS_WIDTH +: GBUS_WIDTH];
    assign push[h]    = &lane_v;
    assign partial[h] = (|lane_v) && !(&lane_v);
    assign pop[h]     = load && (grant == HEAD_IDX_W'(h));
    assign fifo_full[h] = (count[h] == CNT_W'(FIFO_DEPTH));

    consmax_head_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[h]),
      .pop   (pop[h]),
      .wdata (cns_odata[h*GBUS_DATA +: GBUS_DATA]),
      .rdata (rdata[h]),
      .empty (empty[h]),
      .full  (full[h]),
      .count (count[h])
    );
  end

  // Output register, arbiter pointer and sticky error flags (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_head  <= '0;
      rr_ptr    <= '0;
      ovf_err   <= '0;
      lane_err  <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= rdata[grant];
        out_head  <= grant;
        rr_ptr    <= HEAD_IDX_W'((32'(grant) + 32'd1) % NUM_HEAD);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      ovf_err  <= (err_clr ? '0 : ovf_err)  | (push & full & ~pop);
      lane_err <= (err_clr ? '0 : lane_err) | partial;
    end
  end

endmodule

// File: tb/tb_consmax_bus_drain.sv
// Directed and randomized checks of consmax_bus_drain against a queue-based reference model.
module tb_consmax_bus_drain;
  import consmax_drain_pkg::*;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [GBUS_DATA*NUM_HEAD-1:0]  cns_odata;
  logic [GBUS_WIDTH*NUM_HEAD-1:0] cns_odata_valid;
  logic [GBUS_DATA-1:0]           out_data;
  logic [HEAD_IDX_W-1:0]          out_head;
  logic                           out_valid;
  logic                           out_ready;
  logic [NUM_HEAD-1:0]            fifo_full;
  logic [NUM_HEAD-1:0]            ovf_err;
  logic [NUM_HEAD-1:0]            lane_err;
  logic                           err_clr;

  consmax_bus_drain dut (
    .clk             (clk),
    .rst             (rst),
    .cns_odata       (cns_odata),
    .cns_odata_valid (cns_odata_valid),
    .out_data        (out_data),
    .out_head        (out_head),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .fifo_full       (fifo_full),
    .ovf_err         (ovf_err),
    .lane_err        (lane_err),
    .err_clr         (err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per head plus the visible output word.
  logic [GBUS_DATA-1:0] mq [NUM_HEAD][$];
  logic                 mv;
  logic [31:0]          md;
  int                   mh;
  int                   mrr;
  logic [NUM_HEAD-1:0]  movf;
  logic [NUM_HEAD-1:0]  mlane;
  logic [NUM_HEAD-1:0]  mfull;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    int  g;
    int  popped;
    int  pre;
    logic [GBUS_WIDTH-1:0] v;
    if (rst) begin
      for (int h = 0; h < NUM_HEAD; h++) mq[h].delete();
      mv = 0; md = '0; mh = 0; mrr = 0; movf = '0; mlane = '0; mfull = '0;
      return;
    end
    g = -1;
    for (int k = 0; k < NUM_HEAD; k++)
      if (g < 0 && mq[(mrr + k) % NUM_HEAD].size() > 0) g = (mrr + k) % NUM_HEAD;
    popped = -1;
    if ((!mv || out_ready) && g >= 0) begin
      md = mq[g].pop_front();
      mh = g;
      mv = 1;
      mrr = (g + 1) % NUM_HEAD;
      popped = g;
    end else if (out_ready) begin
      mv = 0;
    end
    if (err_clr) begin
      movf = '0;
      mlane = '0;
    end
    for (int h = 0; h < NUM_HEAD; h++) begin
      v = cns_odata_valid[h*GBUS_WIDTH +: GBUS_WIDTH];
      pre = mq[h].size() + ((popped == h) ? 1 : 0);
      if (&v) begin
        if (pre == FIFO_DEPTH && popped != h) movf[h] = 1'b1;
        else mq[h].push_back(cns_odata[h*GBUS_DATA +: GBUS_DATA]);
      end else if (|v) begin
        mlane[h] = 1'b1;
      end
      mfull[h] = (mq[h].size() == FIFO_DEPTH);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("out_valid", 32'(out_valid), 32'(mv));
    check("out_data",  out_data,       md);
    check("out_head",  32'(out_head),  32'(mh));
    check("fifo_full", 32'(fifo_full), 32'(mfull));
    check("ovf_err",   32'(ovf_err),   32'(movf));
    check("lane_err",  32'(lane_err),  32'(mlane));
  endtask

  task automatic clear_in();
    cns_odata       = '0;
    cns_odata_valid = '0;
    err_clr         = 1'b0;
    rst             = 1'b0;
  endtask

  task automatic put(input int h, input logic [31:0] d, input logic [GBUS_WIDTH-1:0] v);
    cns_odata[h*GBUS_DATA +: GBUS_DATA]        = d;
    cns_odata_valid[h*GBUS_WIDTH +: GBUS_WIDTH] = v;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    clear_in();

    // Single word latency
    put(2, 32'hA1B2C3D4, 4'hF);
    step();
    check("single_early", 32'(out_valid), 32'd0);
    clear_in();
    step();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", out_data, 32'hA1B2C3D4);
    check("single_head", 32'(out_head), 32'd2);
    step();
    check("single_gone", 32'(out_valid), 32'd0);

    // Round-robin from a fresh pointer
    rst = 1'b1;
    step();
    clear_in();
    for (int h = 0; h < NUM_HEAD; h++) put(h, 32'(h), 4'hF);
    step();
    clear_in();
    for (int k = 0; k < NUM_HEAD; k++) begin
      step();
      check("rr_head", 32'(out_head), 32'(k));
    end
    step();

    // Backpressure and overflow on head 1
    out_ready = 1'b0;
    for (int w = 1; w <= 6; w++) begin
      put(1, 32'(w), 4'hF);
      step();
    end
    clear_in();
    check("ovf_full", 32'(fifo_full), 32'h2);
    check("ovf_err", 32'(ovf_err), 32'h2);
    check("ovf_hold", out_data, 32'd1);
    out_ready = 1'b1;
    for (int w = 2; w <= 5; w++) begin
      step();
      check("ovf_order", out_data, 32'(w));
    end
    step();
    check("ovf_drained", 32'(out_valid), 32'd0);
    err_clr = 1'b1;
    step();
    clear_in();

    // Push into a full FIFO in the same cycle it is popped
    out_ready = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      put(0, 32'h100 + 32'(w), 4'hF);
      step();
    end
    clear_in();
    check("fp_full", 32'(fifo_full[0]), 32'd1);
    out_ready = 1'b1;
    put(0, 32'hDEAD0001, 4'hF);
    step();
    clear_in();
    check("fp_no_ovf", 32'(ovf_err), 32'd0);
    for (int k = 0; k < 4; k++) step();
    check("fp_last", out_data, 32'hDEAD0001);
    step();

    // Partial lanes and error clear priority
    put(3, 32'h55, 4'b0110);
    step();
    clear_in();
    check("lane_set", 32'(lane_err), 32'h8);
    check("lane_noword", 32'(out_valid), 32'd0);
    put(3, 32'h66, 4'b0011);
    err_clr = 1'b1;
    step();
    clear_in();
    check("lane_setwins", 32'(lane_err), 32'h8);
    err_clr = 1'b1;
    step();
    clear_in();
    check("lane_clr", 32'(lane_err), 32'h0);

    // Reset with words in flight
    out_ready = 1'b0;
    for (int h = 0; h < NUM_HEAD; h++) put(h, 32'hC0DE0000 + 32'(h), 4'hF);
    step();
    clear_in();
    step();
    check("mid_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    clear_in();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("mid_no_stale", 32'(out_valid), 32'd0);
    end

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int h = 0; h < NUM_HEAD; h++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 5)      put(h, $urandom, 4'hF);
        else if (r < 9) put(h, $urandom, 4'h0);
        else            put(h, $urandom, 4'($urandom_range(1, 14)));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    clear_in();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
